axi_lite_read_data_slave: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_read_data_slave_if.sv | 28 ++
 rtl/axi_lite_read_data_slave.sv | 121 ++++++++++++
 tb/tb_axi_lite_read_data_slave.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions.
// Contents: the read response encodings and the state encoding of the read slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,  // waiting for an address
        RD_WAIT = 2'd1,  // counting the register-file read latency
        RD_RESP = 2'd2   // RVALID held until the master takes the beat
    } rd_state_e;

endpackage : axi_lite_pkg

// File: rtl/axi_lite_read_data_slave_if.sv
// AXI4-Lite read-address and read-data channels.
// slave modport : ARVALID/ARADDR/ARPROT/RREADY in, ARREADY/RVALID/RDATA/RRESP out.
// master modport: the mirror image.
interface axi_lite_read_data_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

endinterface : axi_lite_read_data_slave_if

// File: rtl/axi_lite_read_data_slave.sv
// AXI4-Lite slave read path with a single outstanding transaction.
// Accepts an AR beat, decodes it into a register index, strobes a fixed-latency
// register-file read and returns the word (or an error response) on R.
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus           : AR/R channels (slave modport)
//   rd_en/rd_addr : register-file read strobe and word index
//   rd_data       : register-file output, valid RD_LATENCY cycles after rd_en
module axi_lite_read_data_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    NUM_REGS     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    RD_LATENCY   = 1,
    parameter bit                    REQUIRE_PRIV = 1'b0
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi_lite_read_data_slave_if.slave   bus,
    output logic                        rd_en,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]       rd_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    rd_state_e             state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rst_done_q;

    logic                  ar_hs;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  in_range;
    logic                  prot_ok;
    logic                  unused_bits;

    // ARREADY waits one edge after reset release so the first handshake never
    // lands on the release edge itself.
    assign bus.ARREADY = (state_q == RD_IDLE) && rst_done_q;
    assign bus.RVALID  = (state_q == RD_RESP);
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    assign ar_hs = bus.ARVALID && bus.ARREADY;

    // Word index relative to BASE_ADDR; the byte offset bits are dropped.
    assign off      = bus.ARADDR - BASE_ADDR;
    assign idx_full = {2'b00, off[ADDR_WIDTH-1:2]};
    assign in_range = (bus.ARADDR >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(NUM_REGS));
    assign prot_ok  = !REQUIRE_PRIV || bus.ARPROT[0];

    assign rd_en   = ar_hs && in_range && prot_ok;
    assign rd_addr = idx_full[IDX_W-1:0];

    assign unused_bits = ^{off[1:0], bus.ARPROT[2:1]};

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        unique case (state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    if (!in_range) begin
                        // Decode error wins over a protection error.
                        state_d = RD_RESP;
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end else if (!prot_ok) begin
                        state_d = RD_RESP;
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 3'(RD_LATENCY);
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // cnt_q==1 is the cycle in which rd_data is valid.
                if (cnt_q == 3'd1) begin
                    state_d = RD_RESP;
                    rdata_d = rd_data;
                    rresp_d = RESP_OKAY;
                end
            end
            RD_RESP: begin
                if (bus.RREADY) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rst_done_q <= 1'b1;
        end
    end

endmodule : axi_lite_read_data_slave

// File: tb/tb_axi_lite_read_data_slave.sv
// Directed bench for axi_lite_read_data_slave. Three instances cover
// RD_LATENCY=1, RD_LATENCY=3 and REQUIRE_PRIV=1; all share clock and reset.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_axi_lite_read_data_slave;

    logic ACLK;
    logic ARESETn;

    int total = 0;
    int bad   = 0;

    axi_lite_read_data_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    axi_lite_read_data_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();
    axi_lite_read_data_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_c ();

    logic        rd_en_a, rd_en_b, rd_en_c;
    logic [3:0]  rd_addr_a, rd_addr_b, rd_addr_c;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c;

    axi_lite_read_data_slave #(.NUM_REGS(16), .RD_LATENCY(1), .REQUIRE_PRIV(1'b0)) dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );
    axi_lite_read_data_slave #(.NUM_REGS(16), .RD_LATENCY(3), .REQUIRE_PRIV(1'b0)) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );
    axi_lite_read_data_slave #(.NUM_REGS(16), .RD_LATENCY(1), .REQUIRE_PRIV(1'b1)) dut_c (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus_c),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        bus_a.ARVALID = 1'b0; bus_a.ARADDR = '0; bus_a.ARPROT = '0; bus_a.RREADY = 1'b0;
        bus_b.ARVALID = 1'b0; bus_b.ARADDR = '0; bus_b.ARPROT = '0; bus_b.RREADY = 1'b0;
        bus_c.ARVALID = 1'b0; bus_c.ARADDR = '0; bus_c.ARPROT = '0; bus_c.RREADY = 1'b0;
        rd_data_a = '0; rd_data_b = '0; rd_data_c = '0;

        // Reset state
        repeat (2) next_cycle();
        settle();
        check("rst_arready", 32'(bus_a.ARREADY), 32'd0);
        check("rst_rvalid",  32'(bus_a.RVALID),  32'd0);
        check("rst_rdata",   bus_a.RDATA,        32'd0);
        check("rst_rresp",   32'(bus_a.RRESP),   32'd0);
        check("rst_rd_en",   32'(rd_en_a),       32'd0);

        ARESETn = 1'b1;
        settle();
        check("rel_arready_before_edge", 32'(bus_a.ARREADY), 32'd0);
        next_cycle();
        settle();
        check("rel_arready_a", 32'(bus_a.ARREADY), 32'd1);
        check("rel_arready_b", 32'(bus_b.ARREADY), 32'd1);

        // Good read, latency 1, ARADDR 0x8
        bus_a.ARVALID = 1'b1; bus_a.ARADDR = 32'h8;
        settle();
        check("l1_rd_en",   32'(rd_en_a),   32'd1);
        check("l1_rd_addr", 32'(rd_addr_a), 32'd2);
        next_cycle();
        bus_a.ARVALID = 1'b0; rd_data_a = 32'hDEADBEEF;
        settle();
        check("l1_c1_arready", 32'(bus_a.ARREADY), 32'd0);
        check("l1_c1_rvalid",  32'(bus_a.RVALID),  32'd0);
        check("l1_c1_rd_en",   32'(rd_en_a),       32'd0);
        next_cycle();
        rd_data_a = 32'h0;
        settle();
        check("l1_c2_rvalid", 32'(bus_a.RVALID), 32'd1);
        check("l1_c2_rdata",  bus_a.RDATA,       32'hDEADBEEF);
        check("l1_c2_rresp",  32'(bus_a.RRESP),  32'd0);
        bus_a.RREADY = 1'b1;
        next_cycle();
        bus_a.RREADY = 1'b0;
        settle();
        check("l1_c3_arready", 32'(bus_a.ARREADY), 32'd1);
        check("l1_c3_rvalid",  32'(bus_a.RVALID),  32'd0);
        check("l1_c3_rdata",   bus_a.RDATA,        32'hDEADBEEF);

        // Out of range, ARADDR 0x40
        bus_a.ARVALID = 1'b1; bus_a.ARADDR = 32'h40;
        settle();
        check("oor_rd_en", 32'(rd_en_a), 32'd0);
        next_cycle();
        bus_a.ARVALID = 1'b0;
        settle();
        check("oor_rvalid", 32'(bus_a.RVALID), 32'd1);
        check("oor_rresp",  32'(bus_a.RRESP),  32'd3);
        check("oor_rdata",  bus_a.RDATA,       32'd0);
        bus_a.RREADY = 1'b1;
        next_cycle();
        bus_a.RREADY = 1'b0;
        settle();
        check("oor_arready", 32'(bus_a.ARREADY), 32'd1);
        check("oor_rvalid_drop", 32'(bus_a.RVALID), 32'd0);

        // Privilege required: unprivileged read
        bus_c.ARVALID = 1'b1; bus_c.ARADDR = 32'h4; bus_c.ARPROT = 3'b000;
        settle();
        check("priv_bad_rd_en", 32'(rd_en_c), 32'd0);
        next_cycle();
        bus_c.ARVALID = 1'b0;
        settle();
        check("priv_bad_rvalid", 32'(bus_c.RVALID), 32'd1);
        check("priv_bad_rresp",  32'(bus_c.RRESP),  32'd2);
        check("priv_bad_rdata",  bus_c.RDATA,       32'd0);
        bus_c.RREADY = 1'b1;
        next_cycle();
        bus_c.RREADY = 1'b0;
        settle();
        check("priv_bad_arready", 32'(bus_c.ARREADY), 32'd1);

        // Privilege required: privileged read
        bus_c.ARVALID = 1'b1; bus_c.ARADDR = 32'h4; bus_c.ARPROT = 3'b001;
        settle();
        check("priv_ok_rd_en",   32'(rd_en_c),   32'd1);
        check("priv_ok_rd_addr", 32'(rd_addr_c), 32'd1);
        next_cycle();
        bus_c.ARVALID = 1'b0; rd_data_c = 32'hA5A50001;
        next_cycle();
        rd_data_c = 32'h0;
        settle();
        check("priv_ok_rvalid", 32'(bus_c.RVALID), 32'd1);
        check("priv_ok_rresp",  32'(bus_c.RRESP),  32'd0);
        check("priv_ok_rdata",  bus_c.RDATA,       32'hA5A50001);
        bus_c.RREADY = 1'b1;
        next_cycle();
        bus_c.RREADY = 1'b0;

        // Out of range and unprivileged: decode error wins
        bus_c.ARVALID = 1'b1; bus_c.ARADDR = 32'h40; bus_c.ARPROT = 3'b000;
        settle();
        check("prec_rd_en", 32'(rd_en_c), 32'd0);
        next_cycle();
        bus_c.ARVALID = 1'b0;
        settle();
        check("prec_rresp", 32'(bus_c.RRESP), 32'd3);
        bus_c.RREADY = 1'b1;
        next_cycle();
        bus_c.RREADY = 1'b0;

        // Latency 3, ARADDR 0x3C, RREADY already high when RVALID rises
        bus_b.ARVALID = 1'b1; bus_b.ARADDR = 32'h3C;
        settle();
        check("l3_rd_en",   32'(rd_en_b),   32'd1);
        check("l3_rd_addr", 32'(rd_addr_b), 32'd15);
        next_cycle();
        bus_b.ARVALID = 1'b0; rd_data_b = 32'h11111111;
        settle();
        check("l3_c1_rvalid", 32'(bus_b.RVALID), 32'd0);
        next_cycle();
        rd_data_b = 32'h22222222;
        next_cycle();
        rd_data_b = 32'hCAFE0003; bus_b.RREADY = 1'b1;
        settle();
        check("l3_c3_rvalid", 32'(bus_b.RVALID), 32'd0);
        next_cycle();
        rd_data_b = 32'h33333333;
        settle();
        check("l3_c4_rvalid", 32'(bus_b.RVALID), 32'd1);
        check("l3_c4_rdata",  bus_b.RDATA,       32'hCAFE0003);
        next_cycle();
        bus_b.RREADY = 1'b0;
        settle();
        check("l3_c5_rvalid",  32'(bus_b.RVALID),  32'd0);
        check("l3_c5_arready", 32'(bus_b.ARREADY), 32'd1);

        // Latency 3, ARADDR 0x3F, R stalled, second AR held off
        bus_b.ARVALID = 1'b1; bus_b.ARADDR = 32'h3F;
        settle();
        check("stall_rd_en",   32'(rd_en_b),   32'd1);
        check("stall_rd_addr", 32'(rd_addr_b), 32'd15);
        next_cycle();
        bus_b.ARADDR = 32'h0; rd_data_b = 32'h00000001;
        settle();
        check("stall_wait_arready", 32'(bus_b.ARREADY), 32'd0);
        check("stall_wait_rd_en",   32'(rd_en_b),       32'd0);
        next_cycle();
        rd_data_b = 32'h00000002;
        next_cycle();
        rd_data_b = 32'h12345678;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            rd_data_b = 32'hFFFF0000 | 32'(k);
            settle();
            check("stall_rvalid",  32'(bus_b.RVALID),  32'd1);
            check("stall_rdata",   bus_b.RDATA,        32'h12345678);
            check("stall_rresp",   32'(bus_b.RRESP),   32'd0);
            check("stall_arready", 32'(bus_b.ARREADY), 32'd0);
            check("stall_rd_en",   32'(rd_en_b),       32'd0);
            next_cycle();
        end
        bus_b.RREADY = 1'b1;
        settle();
        check("stall_hs_rvalid",  32'(bus_b.RVALID),  32'd1);
        check("stall_hs_arready", 32'(bus_b.ARREADY), 32'd0);
        next_cycle();
        bus_b.RREADY = 1'b0;
        settle();
        check("stall_post_rvalid",  32'(bus_b.RVALID),  32'd0);
        check("stall_post_arready", 32'(bus_b.ARREADY), 32'd1);
        check("stall_post_rd_en",   32'(rd_en_b),       32'd1);
        check("stall_post_rd_addr", 32'(rd_addr_b),     32'd0);

        // Reset pulse while the second read is in WAIT
        next_cycle();
        bus_b.ARVALID = 1'b0; rd_data_b = 32'h5555AAAA;
        settle();
        check("rstw_pre_arready_b", 32'(bus_b.ARREADY), 32'd0);
        check("rstw_pre_arready_a", 32'(bus_a.ARREADY), 32'd1);
        ARESETn = 1'b0;
        settle();
        check("rstw_arready_a", 32'(bus_a.ARREADY), 32'd0);
        check("rstw_arready_b", 32'(bus_b.ARREADY), 32'd0);
        check("rstw_rvalid_b",  32'(bus_b.RVALID),  32'd0);
        check("rstw_rdata_b",   bus_b.RDATA,        32'd0);
        next_cycle();
        ARESETn = 1'b1;
        settle();
        check("rstw_rel_arready", 32'(bus_b.ARREADY), 32'd0);
        check("rstw_rel_rvalid",  32'(bus_b.RVALID),  32'd0);
        next_cycle();
        settle();
        check("rstw_e1_arready", 32'(bus_b.ARREADY), 32'd1);
        check("rstw_e1_rvalid",  32'(bus_b.RVALID),  32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check("rstw_no_beat",  32'(bus_b.RVALID), 32'd0);
            check("rstw_rdata",    bus_b.RDATA,       32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi_lite_read_data_slave
